// File: rtl/rc4_pkg.sv
// Shared RC4 key-search definitions: message-length default, plaintext
// character bounds and the message-checker state encoding.
package rc4_pkg;

    localparam int unsigned MSG_LEN_DEFAULT = 32;

    // Plausible plaintext is lowercase ASCII or space
    localparam logic [7:0] CHAR_SPACE  = 8'h20;
    localparam logic [7:0] CHAR_LO_MIN = 8'h61;
    localparam logic [7:0] CHAR_LO_MAX = 8'h7A;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        FIN   = 3'd4
    } chk_state_t;

endpackage

// File: rtl/rc4_char_classifier.sv
// Combinational plaintext character classifier.
// Ports:
//   ch       - byte to classify
//   is_legal - 1 when ch is a space or a lowercase letter 'a'..'z'
module rc4_char_classifier
    import rc4_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_legal
);

    assign is_legal = (ch == CHAR_SPACE) ||
                      ((ch >= CHAR_LO_MIN) && (ch <= CHAR_LO_MAX));

endmodule

// File: rtl/decrypt_msg_checker.sv
// Scans the decrypted-message RAM after decryption and reports whether every
// byte is plausible plaintext (lowercase letter or space).
// Build option: define MSG_CHECK_EARLY_ABORT_EN to stop the scan at the first
// illegal byte; otherwise all MSG_LEN bytes are always scanned.
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   start        - one-cycle scan request, accepted only in IDLE
//   q_d          - d_memory read data (one cycle after address registered)
//   addr_d       - registered d_memory read address
//   busy         - scan in progress
//   done         - one-cycle pulse when the verdict is final
//   msg_valid    - 1 when every checked byte was legal
//   fail_index   - index of the first illegal byte (0 when msg_valid=1)
//   bad_count    - number of illegal bytes seen in the last scan
module decrypt_msg_checker
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = MSG_LEN_DEFAULT,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] q_d,
    output logic [ADDR_W-1:0] addr_d,
    output logic              busy,
    output logic              done,
    output logic              msg_valid,
    output logic [ADDR_W-1:0] fail_index,
    output logic [8:0]        bad_count
);

    // One extra index bit so MSG_LEN = 2**ADDR_W terminates without wrapping
    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned CNT_W = 9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    chk_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic [ADDR_W-1:0] addr_nxt, fail_nxt;
    logic [CNT_W-1:0]  bad_nxt;
    logic              busy_nxt, done_nxt, valid_nxt;
    logic              is_legal, abort_scan, end_scan;

    rc4_char_classifier u_classifier (
        .ch       (q_d[7:0]),
        .is_legal (is_legal)
    );

`ifdef MSG_CHECK_EARLY_ABORT_EN
    assign abort_scan = ~is_legal;
`else
    assign abort_scan = 1'b0;
`endif

    assign end_scan = (idx_q == LAST_IDX) || abort_scan;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SET;
            SET:     state_d = WAIT;
            WAIT:    state_d = CHECK;
            CHECK:   state_d = end_scan ? FIN : SET;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and scan index
    always_comb begin
        idx_nxt   = idx_q;
        addr_nxt  = addr_d;
        fail_nxt  = fail_index;
        bad_nxt   = bad_count;
        busy_nxt  = busy;
        valid_nxt = msg_valid;
        done_nxt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_nxt   = '0;
                    fail_nxt  = '0;
                    bad_nxt   = '0;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            SET: begin
                addr_nxt = idx_q[ADDR_W-1:0];
            end
            CHECK: begin
                if (!is_legal) begin
                    bad_nxt = bad_count + CNT_W'(1);
                    if (bad_count == '0) fail_nxt = idx_q[ADDR_W-1:0];
                end
                if (end_scan) begin
                    // Verdict lands together with done, including this byte
                    done_nxt  = 1'b1;
                    valid_nxt = is_legal && (bad_count == '0);
                end else begin
                    idx_nxt = idx_q + IDX_W'(1);
                end
            end
            FIN: begin
                busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Output and index registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q      <= '0;
            addr_d     <= '0;
            fail_index <= '0;
            bad_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            msg_valid  <= 1'b0;
        end else begin
            idx_q      <= idx_nxt;
            addr_d     <= addr_nxt;
            fail_index <= fail_nxt;
            bad_count  <= bad_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            msg_valid  <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_decrypt_msg_checker.sv
// Directed self-checking bench for decrypt_msg_checker (32-byte and 1-byte
// instances, each backed by a synchronous-read RAM model).
module tb_decrypt_msg_checker;

`ifdef MSG_CHECK_EARLY_ABORT_EN
    localparam int T2_DONE = 19;
    localparam int T3_DONE = 4;
    localparam int T3_BAD  = 1;
`else
    localparam int T2_DONE = 97;
    localparam int T3_DONE = 97;
    localparam int T3_BAD  = 3;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, start1;
    logic [7:0] q_d, q_d1;
    logic [7:0] addr_d, addr_d1;
    logic       busy, busy1, done, done1, msg_valid, msg_valid1;
    logic [7:0] fail_index, fail_index1;
    logic [8:0] bad_count, bad_count1;

    logic [7:0] mem  [0:255];
    logic [7:0] mem1 [0:255];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) q_d  <= mem[addr_d];
    always @(posedge clk) q_d1 <= mem1[addr_d1];

    decrypt_msg_checker #(.MSG_LEN(32), .ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .q_d        (q_d),
        .addr_d     (addr_d),
        .busy       (busy),
        .done       (done),
        .msg_valid  (msg_valid),
        .fail_index (fail_index),
        .bad_count  (bad_count)
    );

    decrypt_msg_checker #(.MSG_LEN(1), .ADDR_W(8), .DATA_W(8)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start1),
        .q_d        (q_d1),
        .addr_d     (addr_d1),
        .busy       (busy1),
        .done       (done1),
        .msg_valid  (msg_valid1),
        .fail_index (fail_index1),
        .bad_count  (bad_count1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic load_msg(input string s);
        for (int i = 0; i < 256; i++) mem[i] = 8'h20;
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  32'(addr_d),     32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_valid"}, 32'(msg_valid),  32'd0);
        check({tag, "_fidx"},  32'(fail_index), 32'd0);
        check({tag, "_bad"},   32'(bad_count),  32'd0);
    endtask

    // Pulse start, then observe 110 cycles; cycle 1 is the first after start is sampled
    task automatic scan32(input int restart_at, output int done_cyc, output int pulses,
                          output int addr_bad, output int busy_bad);
        done_cyc = 0; pulses = 0; addr_bad = 0; busy_bad = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= 110; c++) begin
            start = (c == restart_at);
            if (done) begin
                pulses++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (done_cyc == 0 && c <= 96) begin
                if (((c - 1) % 3) != 0 && addr_d != 8'((c - 1) / 3)) addr_bad++;
            end
            if (addr_d > 8'd31) addr_bad++;
            if ((done_cyc == 0 || c == done_cyc) != busy) busy_bad++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic scan1(input logic [7:0] v, output int done_cyc);
        done_cyc = 0;
        mem1[0] = v;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (done1 && done_cyc == 0) done_cyc = c;
            @(negedge clk);
        end
    endtask

    initial begin
        int dc, np, ab, bb;
        logic [7:0] bvals [6];
        logic       bexp  [6];
        bvals = '{8'h20, 8'h61, 8'h7A, 8'h1F, 8'h21, 8'h7B};
        bexp  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0; start = 1'b0; start1 = 1'b0;
        load_msg("");
        for (int i = 0; i < 256; i++) mem1[i] = 8'h20;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Clean message
        load_msg("attack at dawn");
        scan32(0, dc, np, ab, bb);
        check("clean_done_cyc", 32'(dc), 32'd97);
        check("clean_pulses",   32'(np), 32'd1);
        check("clean_addr_seq", 32'(ab), 32'd0);
        check("clean_busy",     32'(bb), 32'd0);
        check("clean_valid",    32'(msg_valid),  32'd1);
        check("clean_fidx",     32'(fail_index), 32'd0);
        check("clean_bad",      32'(bad_count),  32'd0);

        // Uppercase at byte 5
        load_msg("attack at dawn");
        mem[5] = 8'h41;
        scan32(0, dc, np, ab, bb);
        check("b5_done_cyc", 32'(dc), 32'(T2_DONE));
        check("b5_pulses",   32'(np), 32'd1);
        check("b5_addr_seq", 32'(ab), 32'd0);
        check("b5_busy",     32'(bb), 32'd0);
        check("b5_valid",    32'(msg_valid),  32'd0);
        check("b5_fidx",     32'(fail_index), 32'd5);
        check("b5_bad",      32'(bad_count),  32'd1);

        // Illegal bytes at 0, 10, 31
        load_msg("attack at dawn");
        mem[0] = 8'h00; mem[10] = 8'h7B; mem[31] = 8'h60;
        scan32(0, dc, np, ab, bb);
        check("multi_done_cyc", 32'(dc), 32'(T3_DONE));
        check("multi_pulses",   32'(np), 32'd1);
        check("multi_busy",     32'(bb), 32'd0);
        check("multi_valid",    32'(msg_valid),  32'd0);
        check("multi_fidx",     32'(fail_index), 32'd0);
        check("multi_bad",      32'(bad_count),  32'(T3_BAD));

        // Boundary characters on the single-byte instance
        for (int i = 0; i < 6; i++) begin
            scan1(bvals[i], dc);
            check($sformatf("len1_%0h_done_cyc", bvals[i]), 32'(dc), 32'd4);
            check($sformatf("len1_%0h_valid", bvals[i]), 32'(msg_valid1), 32'(bexp[i]));
            check($sformatf("len1_%0h_bad", bvals[i]), 32'(bad_count1), 32'(!bexp[i]));
            check($sformatf("len1_%0h_addr", bvals[i]), 32'(addr_d1), 32'd0);
        end

        // start during a running scan is ignored
        load_msg("attack at dawn");
        scan32(10, dc, np, ab, bb);
        check("restart_pulses",   32'(np), 32'd1);
        check("restart_done_cyc", 32'(dc), 32'd97);
        check("restart_valid",    32'(msg_valid), 32'd1);

        // Reset mid-scan at cycle 40
        load_msg("attack at dawn");
        mem[5] = 8'h41;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (38) @(negedge clk);
        check("pre_rst_fidx", 32'(fail_index), 32'd5);
        check("pre_rst_bad",  32'(bad_count),  32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        // start held while in reset must not begin a scan
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 32'd0);

        load_msg("attack at dawn");
        scan32(0, dc, np, ab, bb);
        check("post_rst_done_cyc", 32'(dc), 32'd97);
        check("post_rst_valid",    32'(msg_valid),  32'd1);
        check("post_rst_fidx",     32'(fail_index), 32'd0);
        check("post_rst_bad",      32'(bad_count),  32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
